// File: rtl/alu_op_issuer.sv
// Command front-end for the 8-bit six-control-bit ALU: decodes an op mnemonic, drives registered
// ALU inputs, waits the settle latency and returns o/zr/ng over a valid/ready response channel.
module alu_op_issuer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zr,
  output logic             rsp_ng,
  output logic             rsp_err
);

  localparam logic [3:0] LatM1 = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic [5:0]       alu_ctl_q, alu_ctl_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zr_q, rsp_zr_d, rsp_ng_q, rsp_ng_d, rsp_err_q, rsp_err_d;
  logic             op_legal;
  logic [5:0]       op_ctl;

  // Returns {legal, zx, nx, zy, ny, f, no}.
  function automatic logic [6:0] decode_op(input logic [4:0] op);
    unique case (op)
      5'd0:    return 7'b1_101010;
      5'd1:    return 7'b1_111111;
      5'd2:    return 7'b1_111010;
      5'd3:    return 7'b1_001100;
      5'd4:    return 7'b1_110000;
      5'd5:    return 7'b1_001101;
      5'd6:    return 7'b1_110001;
      5'd7:    return 7'b1_001111;
      5'd8:    return 7'b1_110011;
      5'd9:    return 7'b1_011111;
      5'd10:   return 7'b1_110111;
      5'd11:   return 7'b1_001110;
      5'd12:   return 7'b1_110010;
      5'd13:   return 7'b1_000010;
      5'd14:   return 7'b1_010011;
      5'd15:   return 7'b1_000111;
      5'd16:   return 7'b1_000000;
      5'd17:   return 7'b1_010101;
      default: return 7'b0_000000;
    endcase
  endfunction

  assign {op_legal, op_ctl} = decode_op(req_op);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_x_d    = alu_x_q;
    alu_y_d    = alu_y_q;
    alu_ctl_d  = alu_ctl_q;
    rsp_data_d = rsp_data_q;
    rsp_zr_d   = rsp_zr_q;
    rsp_ng_d   = rsp_ng_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (op_legal) begin
            alu_x_d   = req_x;
            alu_y_d   = req_y;
            alu_ctl_d = op_ctl;
            cnt_d     = LatM1;
            state_d   = StWait;
          end else begin
            // Illegal codes never touch the ALU; answer straight away with an error.
            rsp_data_d = '0;
            rsp_zr_d   = 1'b0;
            rsp_ng_d   = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = alu_o;
          rsp_zr_d   = alu_zr;
          rsp_ng_d   = alu_ng;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      alu_ctl_q  <= 6'd0;
      rsp_data_q <= '0;
      rsp_zr_q   <= 1'b0;
      rsp_ng_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_x_q    <= alu_x_d;
      alu_y_q    <= alu_y_d;
      alu_ctl_q  <= alu_ctl_d;
      rsp_data_q <= rsp_data_d;
      rsp_zr_q   <= rsp_zr_d;
      rsp_ng_q   <= rsp_ng_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_ctl   = alu_ctl_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_ng    = rsp_ng_q;
  assign rsp_err   = rsp_err_q;

endmodule
